// File: rtl/uart_rx_bridge.sv
// 8N1 UART receiver: turns the FTDI rx line into a held byte for ui_in,
// with a one-cycle strobe per good byte and a framing-error strobe.
module uart_rx_bridge #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [7:0]  HOLD_RESET   = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy,
    output logic [7:0] held_byte
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t           state_q;
    logic             sync1_q;
    logic             rx_s_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       idx_q;
    logic [7:0]       shreg_q;
    logic [7:0]       rx_data_q;
    logic [7:0]       held_q;
    logic             rx_valid_q;
    logic             frame_err_q;
    logic             busy_q;

    // Two-flop synchroniser; the line idles high so both flops reset to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == DATA && cnt_q == LAST) begin
            shreg_q[idx_q] <= rx_s_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            rx_data_q   <= '0;
            held_q      <= HOLD_RESET;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s_q) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == HALF) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        if (!rx_s_q) begin
                            state_q <= DATA;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == LAST) begin
                        cnt_q <= '0;
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == LAST) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            rx_data_q  <= shreg_q;
                            held_q     <= shreg_q;
                            rx_valid_q <= 1'b1;
                            state_q    <= IDLE;
                            busy_q     <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                BREAK: begin
                    // Only one frame_err per held-low line; wait for it to release.
                    cnt_q <= '0;
                    if (rx_s_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
    assign held_byte = held_q;

endmodule

// File: tb/tb_uart_rx_bridge.sv
// Scoreboard bench for uart_rx_bridge at 8 clocks per bit: stimulus pushes
// expected strobes (kind, data, held byte, cycle); a negedge monitor pops them.
module tb_uart_rx_bridge;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
    logic [7:0] held_byte;

    uart_rx_bridge #(
        .CLKS_PER_BIT(CPB),
        .HOLD_RESET  (8'h00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy),
        .held_byte(held_byte)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       err;
        logic [7:0] data;
        logic [7:0] held;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start-bit pin edge after cycle c gives a strobe visible at cycle c+79
    // (mid-stop sample at 9.5 bit times, plus sync and output register).
    task automatic send(input logic [7:0] d, input logic stop_bit, input logic [7:0] held_exp);
        exp_t e;
        e.err  = ~stop_bit;
        e.data = d;
        e.held = held_exp;
        e.cyc  = cyc + 79;
        exp_q.push_back(e);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) tick();
        end
        rx = stop_bit;
        repeat (CPB) tick();
    endtask

    always @(negedge clk) begin
        if (rx_valid || frame_err) begin
            check("strobe_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe actual valid=%0b err=%0b required none", rx_valid, frame_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_kind_err", {31'd0, frame_err}, {31'd0, e.err});
                check("strobe_cycle", cyc, e.cyc);
                check("strobe_held", {24'd0, held_byte}, {24'd0, e.held});
                if (!e.err) begin
                    check("strobe_rx_data", {24'd0, rx_data}, {24'd0, e.data});
                    check("strobe_busy_low", {31'd0, busy}, 32'd0);
                end else begin
                    check("err_rx_data_kept", {24'd0, rx_data}, {24'd0, e.held});
                    check("err_busy_high", {31'd0, busy}, 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) tick();
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_held", {24'd0, held_byte}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_strobes", {30'd0, rx_valid, frame_err}, 32'd0);
        rst = 1'b0;
        repeat (5) tick();

        send(8'hA5, 1'b1, 8'hA5);
        repeat (5) tick();
        check("a5_held", {24'd0, held_byte}, 32'hA5);

        send(8'h3C, 1'b1, 8'h3C);
        send(8'hFF, 1'b1, 8'hFF);
        repeat (10) tick();
        check("b2b_held", {24'd0, held_byte}, 32'hFF);

        rx = 1'b0;
        tick();
        tick();
        rx = 1'b1;
        tick();
        check("glitch_busy_seen", {31'd0, busy}, 32'd1);
        repeat (20) tick();
        check("glitch_idle", {31'd0, busy}, 32'd0);
        check("glitch_held", {24'd0, held_byte}, 32'hFF);

        send(8'h55, 1'b0, 8'hFF);
        repeat (40) tick();
        check("break_busy", {31'd0, busy}, 32'd1);
        check("break_held", {24'd0, held_byte}, 32'hFF);
        rx = 1'b1;
        repeat (4) tick();
        check("break_release_idle", {31'd0, busy}, 32'd0);

        // 0x81 aborted by reset in the middle of data bit 4.
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0);
            repeat (CPB) tick();
        end
        rx = 1'b0;
        repeat (4) tick();
        check("midframe_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        rx  = 1'b1;
        tick();
        tick();
        check("midrst_held", {24'd0, held_byte}, 32'd0);
        check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (20) tick();

        send(8'h81, 1'b1, 8'h81);
        repeat (20) tick();
        check("final_held", {24'd0, held_byte}, 32'h81);
        check("pending_expected", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_bridge.md
Name: uart_rx_bridge

Overview:
- UART receiver sitting between the board FTDI `usb_rx` pin and the moody mimosa `ui_in` bus in the FPGA top.
- Deserialises 8N1 frames into a held byte register that drives `ui_in`.
- Also emits a one-cycle strobe per received byte and a framing-error strobe.
- Lets a host PC drive the design's inputs over USB instead of from the physical port pins.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 4.
- HOLD_RESET, 8'h00, value loaded into `held_byte` on reset.

Ports:
- clk  input  1  main clock.
- rst  input  1  synchronous reset, active-high.
- rx  input  1  asynchronous UART line from FTDI; idles high.
- rx_data  output  8  last correctly framed byte.
- rx_valid  output  1  one-cycle strobe; `rx_data` updated this cycle.
- frame_err  output  1  one-cycle strobe; stop bit sampled low.
- busy  output  1  high in any state other than IDLE.
- held_byte  output  8  byte driven onto `ui_in`; updates only on good frames.

Behaviour:
- Reset is synchronous and active-high, on the `clk` rising edge with `rst`=1. Reset values:
  - state = IDLE
  - both sync flops = 1
  - `rx_data` = 0
  - `held_byte` = HOLD_RESET
  - `rx_valid` = `frame_err` = `busy` = 0
  - counters = 0
- Reset mid-frame aborts the frame immediately; no strobes are emitted.
- `rx` passes through a 2-flop synchroniser; `rx_s` is the second flop output. All decisions use `rx_s`.
- Bit counter `cnt` has width clog2(CLKS_PER_BIT); bit index `idx` is 3 bits.
- State machine:
  - IDLE: when `rx_s`==0, go to START with `cnt`=0.
  - START: count to (CLKS_PER_BIT/2)-1, which is mid start bit.
    - If `rx_s`==0 there: go to DATA with `cnt`=0, `idx`=0.
    - If `rx_s`==1 there: glitch; return to IDLE with no strobe.
  - DATA: when `cnt`==CLKS_PER_BIT-1:
    - shift `rx_s` into shift register bit `idx` (LSB first), then `cnt`=0.
    - if `idx`==7 go to STOP, else `idx`++.
  - STOP: when `cnt`==CLKS_PER_BIT-1, sample `rx_s`:
    - 1: next cycle `rx_data`=`held_byte`=shift register, `rx_valid`=1 for exactly one cycle; state goes to IDLE.
    - 0: next cycle `frame_err`=1 for one cycle; `rx_data` and `held_byte` unchanged; state goes to BREAK.
  - BREAK: wait for `rx_s`==1, then go to IDLE. A held-low break line produces exactly one `frame_err`.
- Sampling timing:
  - Each data bit is sampled CLKS_PER_BIT cycles after the previous sample point.
  - The first data bit is sampled CLKS_PER_BIT after the mid-start sample.
- Latency: the `rx_valid` edge comes 1 cycle after the mid-stop sample, i.e. about 9.5 bit times plus 3 cycles (sync plus register) after the start-bit falling edge at the pin.
- `rx_valid` and `frame_err` are never high together.
- `busy`=0 only in IDLE.
- Back-to-back frames: a start edge in the cycle immediately after the STOP→IDLE transition is accepted. No gap beyond the stop bit is required.
- Free-running; there is no backpressure. A new byte overwrites `rx_data` and `held_byte` regardless of whether the consumer has read it.
- Counter arithmetic does not wrap within a state. `cnt` is cleared on every state transition.

Test Plan:
- Reset: assert `rst` with `rx`=1, CLKS_PER_BIT=8 -> `held_byte`=8'h00, `rx_data`=0, `busy`=0, no strobes.
- Good frame: send 0xA5 at 8 clks/bit -> single-cycle `rx_valid`; `rx_data`=`held_byte`=8'hA5; `frame_err` stays 0; `busy` falls with the strobe.
- Back-to-back: send 0x3C then 0xFF with no idle gap -> two `rx_valid` pulses 80 cycles apart; `held_byte` ends at 8'hFF.
- Glitch: drive `rx` low for 2 cycles then high -> FSM returns to IDLE; no strobes; `held_byte` unchanged.
- Framing error: send 0x55 with stop bit 0, then hold `rx` low for 40 cycles -> exactly one `frame_err` pulse; `held_byte` keeps its previous value; `busy` stays high until `rx` returns to 1, then IDLE.
- Reset mid-frame: assert `rst` during data bit 4 of 0x81 -> no `rx_valid`; `held_byte`=HOLD_RESET; a following 0x81 frame is received correctly.
